apb4_regfile_slave: RTL and testbench

// Next-generation APB slave: AMBA 4 (APB4) register file with byte strobes, programmable wait states and real PSLVERR.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb4_strobe_reg.sv | 32 +++
 rtl/apb4_regfile_slave.sv | 137 +++++++++++++
 tb/tb_apb4_regfile_slave.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 register file slave.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

    localparam int APB_WAIT_MAX = 15;
    localparam int APB_CNT_W    = $clog2(APB_WAIT_MAX + 1);

    function automatic int addr_lsb(input int n_bit_data);
        return $clog2(n_bit_data / 8);
    endfunction

    // Expands up to 8 byte strobes into a 64-bit lane mask; callers truncate.
    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb4_strobe_reg.sv
// One register of the bank: byte-lane masked write, or continuous hardware load when read-only.
module apb4_strobe_reg
    import apb_pkg::*;
#(
    parameter int                    N_BIT_DATA  = 32,
    parameter bit                    READ_ONLY   = 1'b0,
    parameter logic [N_BIT_DATA-1:0] RESET_VALUE = '0
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [N_BIT_DATA-1:0] i_mask,
    input  logic [N_BIT_DATA-1:0] i_wdata,
    input  logic [N_BIT_DATA-1:0] i_hw,
    output logic [N_BIT_DATA-1:0] o_q
);

    logic [N_BIT_DATA-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= READ_ONLY ? '0 : RESET_VALUE;
        end else if (READ_ONLY) begin
            r_q <= i_hw;
        end else if (i_we) begin
            r_q <= (r_q & ~i_mask) | (i_wdata & i_mask);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/apb4_regfile_slave.sv
// APB4 register file slave with byte strobes, programmable wait states, PSLVERR and read-only status registers.
module apb4_regfile_slave
    import apb_pkg::*;
#(
    parameter int                    N_BIT_DATA    = 32,
    parameter int                    N_BIT_ADDRESS = 8,
    parameter int                    N_REGS        = 8,
    parameter int                    WAIT_STATES   = 0,
    parameter logic [N_REGS-1:0]     RO_MASK       = '0,
    parameter logic [N_BIT_DATA-1:0] RESET_VALUE   = '0
)(
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [N_BIT_ADDRESS-1:0]     PADDR,
    input  logic [N_BIT_DATA-1:0]        PWDATA,
    input  logic [N_BIT_DATA/8-1:0]      PSTRB,
    input  logic [2:0]                   PPROT,
    output logic [N_BIT_DATA-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [N_REGS*N_BIT_DATA-1:0] hw_status,
    output logic [N_REGS*N_BIT_DATA-1:0] reg_q
);

    localparam int                       ADDR_LSB   = addr_lsb(N_BIT_DATA);
    localparam logic [N_BIT_ADDRESS-1:0] ALIGN_MASK = N_BIT_ADDRESS'((1 << ADDR_LSB) - 1);

    apb_state_t                r_state, w_next_state;
    logic [APB_CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                      w_capture;
    logic                      w_ready;

    logic [N_BIT_ADDRESS-1:0]  r_addr;
    logic                      r_write;
    logic [N_BIT_DATA-1:0]     r_wdata;
    logic [N_BIT_DATA/8-1:0]   r_strb;
    logic [2:0]                r_pprot_unused;

    logic [N_BIT_ADDRESS-1:0]  w_index;
    logic                      w_hit;
    logic                      w_ro;
    logic                      w_err;
    logic                      w_we;
    logic [N_BIT_DATA-1:0]     w_rdata;
    logic [N_BIT_DATA-1:0]     w_mask;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Transfer attributes are frozen at setup; bus changes during ACCESS have no effect.
    always_ff @(posedge PCLK) begin
        if (w_capture) begin
            r_addr         <= PADDR;
            r_write        <= PWRITE;
            r_wdata        <= PWDATA;
            r_strb         <= PSTRB;
            r_pprot_unused <= PPROT;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = APB_CNT_W'(WAIT_STATES);
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    w_next_state = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_ready      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_index = r_addr >> ADDR_LSB;

    always_comb begin
        w_hit   = 1'b0;
        w_ro    = 1'b0;
        w_rdata = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_index == N_BIT_ADDRESS'(i)) begin
                w_hit   = 1'b1;
                w_ro    = RO_MASK[i];
                w_rdata = reg_q[i*N_BIT_DATA +: N_BIT_DATA];
            end
        end
    end

    assign w_err  = (|(r_addr & ALIGN_MASK)) | !w_hit | (r_write & w_ro);
    assign w_we   = w_ready & r_write & !w_err;
    assign w_mask = N_BIT_DATA'(strb_mask(8'(r_strb)));

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready & w_err;
    assign PRDATA  = (w_ready && !w_err) ? w_rdata : '0;

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        apb4_strobe_reg #(
            .N_BIT_DATA  (N_BIT_DATA),
            .READ_ONLY   (RO_MASK[i]),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .i_clk   (PCLK),
            .i_rst   (PRESET),
            .i_we    (w_we && (w_index == N_BIT_ADDRESS'(i))),
            .i_mask  (w_mask),
            .i_wdata (r_wdata),
            .i_hw    (hw_status[i*N_BIT_DATA +: N_BIT_DATA]),
            .o_q     (reg_q[i*N_BIT_DATA +: N_BIT_DATA])
        );
    end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Directed bench for apb4_regfile_slave: three instances with 0, 3 and 2 wait states.
module tb_apb4_regfile_slave;

    logic         clk = 1'b0;
    logic         preset;
    logic [2:0]   sel;
    logic         penable, pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [255:0] hw0, hw1, hw2;
    logic [255:0] rq0, rq1, rq2;
    logic [31:0]  prd [3];
    logic [2:0]   rdy, perr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: zero wait, register 3 read-only.
    apb4_regfile_slave #(.WAIT_STATES(0), .RO_MASK(8'h08)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(sel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prd[0]), .PREADY(rdy[0]), .PSLVERR(perr[0]), .hw_status(hw0), .reg_q(rq0));

    // Instance 1: three wait states, nonzero reset value.
    apb4_regfile_slave #(.WAIT_STATES(3), .RESET_VALUE(32'h0000_5A5A)) dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(sel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prd[1]), .PREADY(rdy[1]), .PSLVERR(perr[1]), .hw_status(hw1), .reg_q(rq1));

    // Instance 2: two wait states, used for the abort case.
    apb4_regfile_slave #(.WAIT_STATES(2)) dut2 (
        .PCLK(clk), .PRESET(preset), .PSEL(sel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prd[2]), .PREADY(rdy[2]), .PSLVERR(perr[2]), .hw_status(hw2), .reg_q(rq2));

    typedef struct {
        int          k;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output bit e, output int w);
        bit done;
        @(posedge clk); #1;
        sel = '0; sel[k] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = ~d;
        paddr   = a ^ 8'h04;
        w = 0; rd = '0; e = 1'b0; done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                rd   = prd[k];
                e    = perr[k];
                done = 1'b1;
            end else begin
                w++;
                @(posedge clk); #1;
            end
        end
        if (!done) w = 99;
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        sel = '0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    bit          e;
    int          w;
    logic        acc;

    initial begin
        preset = 1'b1; sel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b010;
        hw0 = {8{32'hFFFF_FFFF}}; hw0[127:96] = 32'h0;
        hw1 = {8{32'hFFFF_FFFF}};
        hw2 = {8{32'hFFFF_FFFF}};

        for (int i = 0; i < 8; i++)
            vecs.push_back('{0, 1'b0, 8'(i*4), 32'h0, 4'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101, 32'h0, 1'b0, 0});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h0, 4'h0, 32'h00AD_00EF, 1'b0, 0});
        vecs.push_back('{0, 1'b0, 8'h02, 32'h0, 4'h0, 32'h0, 1'b1, 0});
        vecs.push_back('{0, 1'b1, 8'h40, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 0});
        vecs.push_back('{0, 1'b1, 8'h0C, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0});
        vecs.push_back('{0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0});
        vecs.push_back('{1, 1'b1, 8'h08, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 3});
        vecs.push_back('{1, 1'b0, 8'h08, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3});

        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        chk("rst_pready", 256'(rdy), 256'h0);
        chk("rst_pslverr", 256'(perr), 256'h0);
        chk("rst_prdata0", 256'(prd[0]), 256'h0);
        chk("rst_regq0", rq0, 256'h0);
        chk("rst_regq1", rq1, {8{32'h0000_5A5A}});

        foreach (vecs[i]) begin
            xfer(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, e, w);
            chk($sformatf("v%0d_waits", i), 256'(w), 256'(vecs[i].exp_waits));
            chk($sformatf("v%0d_pslverr", i), 256'(e), 256'(vecs[i].exp_err));
            if (!vecs[i].wr)
                chk($sformatf("v%0d_prdata", i), 256'(rd), 256'(vecs[i].exp_rd));
        end
        idle_bus();
        @(negedge clk);
        chk("regq0_reg1", 256'(rq0[63:32]), 256'h00AD_00EF);
        chk("regq0_all", rq0, 256'h00AD_00EF << 32);

        hw0[127:96] = 32'hCAFE_0001;
        idle_bus();
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, e, w);
        chk("ro_prdata", 256'(rd), 256'hCAFE_0001);
        chk("ro_pslverr", 256'(e), 256'h0);

        idle_bus();
        @(posedge clk); #1;
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h00; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        acc = rdy[2];
        sel = '0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | rdy[2];
        end
        chk("abort_pready", 256'(acc), 256'h0);
        chk("abort_reg0", 256'(rq2[31:0]), 256'h0);
        xfer(2, 1'b0, 8'h00, 32'h0, 4'h0, rd, e, w);
        chk("abort_read_waits", 256'(w), 256'd2);
        chk("abort_read_data", 256'(rd), 256'h0);

        xfer(1, 1'b1, 8'h0C, 32'hA5A5_A5A5, 4'hF, rd, e, w);
        chk("b2b_wr_waits", 256'(w), 256'd3);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, e, w);
        chk("b2b_rd_waits", 256'(w), 256'd3);
        chk("b2b_rd_data", 256'(rd), 256'hA5A5_A5A5);

        @(posedge clk); #1;
        sel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h0C; pwdata = 32'h1111_1111; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("midrst_wait", 256'(rdy[1]), 256'h0);
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; sel = '0; penable = 1'b0;
        @(negedge clk);
        chk("midrst_pready", 256'(rdy), 256'h0);
        chk("midrst_pslverr", 256'(perr), 256'h0);
        chk("midrst_reg3", 256'(rq1[127:96]), 256'h0000_5A5A);
        chk("midrst_regq1", rq1, {8{32'h0000_5A5A}});
        chk("midrst_regq0", rq0, 256'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
